serial_magnitude_comparator: RTL



---
 rtl/cmp_pkg.sv | 18 +
 rtl/bcs_cell.sv | 16 +
 rtl/serial_magnitude_comparator.sv | 98 +++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the bit-serial magnitude comparator: FSM encoding and
// the initial values of the running equal/greater flags.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic E_INIT = 1'b1;
  localparam logic G_INIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } cmp_state_t;

endpackage

// File: rtl/bcs_cell.sv
// One bit-comparator slice: folds one operand bit pair into the running
// equal/greater flags, processed MSB first.
module bcs_cell (
  input  logic a1,
  input  logic b1,
  input  logic e0,
  input  logic g0,
  output logic e1,
  output logic g1
);

  // Once a higher bit has differed (e0=0), g0 is final and lower bits are masked.
  assign e1 = e0 & ~(a1 ^ b1);
  assign g1 = g0 | (e0 & a1 & ~b1);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// WIDTH-bit unsigned magnitude comparator evaluated one bit per clock through a
// single bcs_cell, with a start/busy/done handshake and held eq/gt/lt results.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH);

  cmp_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             e_reg, g_reg;
  logic [CNT_W-1:0] idx;
  logic             bit_a, bit_b;
  logic             e_nxt, g_nxt;
  logic             accept;
  logic             last_bit;

  assign bit_a    = a_reg[idx];
  assign bit_b    = b_reg[idx];
  assign last_bit = (idx == '0);

  // The DONE cycle can launch the next request so that a held start yields
  // one result every WIDTH+1 cycles.
  assign accept = start && ((state == IDLE) || (state == DONE));

  bcs_cell u_bcs (
    .a1 (bit_a),
    .b1 (bit_b),
    .e0 (e_reg),
    .g0 (g_reg),
    .e1 (e_nxt),
    .g1 (g_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMPARE;
      COMPARE: if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? COMPARE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      e_reg <= E_INIT;
      g_reg <= G_INIT;
      idx   <= '0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      e_reg <= E_INIT;
      g_reg <= G_INIT;
      idx   <= CNT_W'(WIDTH - 1);
    end else if (state == COMPARE) begin
      e_reg <= e_nxt;
      g_reg <= g_nxt;
      idx   <= idx - CNT_W'(1);
      // Results are taken from the slice so bit 0 is included in this edge.
      if (last_bit) begin
        eq <= e_nxt;
        gt <= g_nxt;
        lt <= ~e_nxt & ~g_nxt;
      end
    end
  end

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

endmodule
